// File: rtl/dma_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_if
// Bundle of every bus-side signal around dma_bus_arbiter: the CPU, DMA RX and
// DMA TX address/strobe inputs, the request/grant handshakes, the muxed RAM
// port and the status outputs.
//
// Modports
//   slave  : the arbiter. Requests, addresses, strobes, cpu_bus_free and
//            err_clr are inputs. Grants, ram_*, owner and hold_err are outputs.
//   master : the environment (CPU, DMA engines, RAM). It uses the same
//            signals with the directions reversed.
// -----------------------------------------------------------------------------
interface dma_bus_arbiter_if #(
  parameter int ADDR_W = 8
);
  // CPU side
  logic              cpu_bus_free;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_cs;
  logic              cpu_oen;
  logic              cpu_wen;
  logic              cpu_grant;

  // DMA RX side
  logic              req_rx;
  logic [ADDR_W-1:0] rx_address;
  logic              rx_cs;
  logic              rx_oen;
  logic              rx_wen;
  logic              gnt_rx;

  // DMA TX side
  logic              req_tx;
  logic [ADDR_W-1:0] tx_address;
  logic              tx_cs;
  logic              tx_oen;
  logic              tx_wen;
  logic              gnt_tx;

  // RAM side
  logic [ADDR_W-1:0] ram_address;
  logic              ram_cs;
  logic              ram_oen;
  logic              ram_wen;

  // Status
  logic              err_clr;
  logic [1:0]        owner;
  logic              hold_err;

  modport slave (
    input  cpu_bus_free, cpu_address, cpu_cs, cpu_oen, cpu_wen,
    input  req_rx, rx_address, rx_cs, rx_oen, rx_wen,
    input  req_tx, tx_address, tx_cs, tx_oen, tx_wen,
    input  err_clr,
    output cpu_grant, gnt_rx, gnt_tx,
    output ram_address, ram_cs, ram_oen, ram_wen,
    output owner, hold_err
  );

  modport master (
    output cpu_bus_free, cpu_address, cpu_cs, cpu_oen, cpu_wen,
    output req_rx, rx_address, rx_cs, rx_oen, rx_wen,
    output req_tx, tx_address, tx_cs, tx_oen, tx_wen,
    output err_clr,
    input  cpu_grant, gnt_rx, gnt_tx,
    input  ram_address, ram_cs, ram_oen, ram_wen,
    input  owner, hold_err
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
// This module shares the system address bus and the RAM strobes between the
// CPU and two DMA masters, RX and TX. The CPU owns the bus by default. A DMA
// master is granted the bus only when the CPU reports an instruction boundary
// (cpu_bus_free). When both DMA masters request at once, a round-robin
// pointer picks the winner. Every DMA grant ends with one dead HANDOVER
// cycle, and then the CPU owns the bus for at least one cycle. A watchdog sets
// a sticky hold_err flag when one grant lasts MAX_HOLD cycles. The grant is
// not revoked.
//
// Parameters
//   ADDR_W   : address bus width
//   MAX_HOLD : number of grant cycles before hold_err is set (>= 1)
//   RX_FIRST : reset value of the priority pointer (1 = RX wins the first tie)
//
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dma_bus_arbiter_if.slave
//           - inputs : cpu_bus_free; cpu/rx/tx address and cs/oen/wen strobes;
//                      req_rx, req_tx; err_clr
//           - outputs: cpu_grant, gnt_rx, gnt_tx (registered, at most one high)
//                      owner (registered: 0 CPU, 1 RX, 2 TX, 3 handover)
//                      hold_err (registered, sticky)
//                      ram_address, ram_cs, ram_oen, ram_wen (combinational
//                      mux selected by the registered state)
// -----------------------------------------------------------------------------
module dma_bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_HOLD = 16,
  parameter int RX_FIRST = 1
) (
  input logic             clk,
  input logic             rst_n,
  dma_bus_arbiter_if.slave bus
);

  // The encoding matches the owner output code, so the state register drives
  // owner directly.
  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    GRANT_RX = 2'd1,
    GRANT_TX = 2'd2,
    HANDOVER = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic PTR_RST = (RX_FIRST != 0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic             ptr;          // 1: RX wins a tie, 0: TX wins a tie
  logic             ptr_next;
  logic             hold_err_q;
  logic             hold_err_next;
  logic             cpu_grant_q;
  logic             gnt_rx_q;
  logic             gnt_tx_q;

  // The hold counter saturates at the limit, so while a long grant stays
  // active the watchdog condition holds every cycle.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == HOLD_LIM) ? v : v + 1'b1;
  endfunction

  // State, pointer, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CPU_OWN;
      hold_cnt    <= '0;
      ptr         <= PTR_RST;
      hold_err_q  <= 1'b0;
      cpu_grant_q <= 1'b1;
      gnt_rx_q    <= 1'b0;
      gnt_tx_q    <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      ptr         <= ptr_next;
      hold_err_q  <= hold_err_next;
      // The grants come from the next state, so they are registered copies
      // of the state decode and change on the same edge as the state.
      cpu_grant_q <= (state_next == CPU_OWN);
      gnt_rx_q    <= (state_next == GRANT_RX);
      gnt_tx_q    <= (state_next == GRANT_TX);
    end
  end

  // Next-state, pointer, counter and watchdog logic
  always_comb begin
    logic [CNT_W-1:0] cnt_inc;
    logic             err_set;

    state_next    = state;
    hold_cnt_next = hold_cnt;
    ptr_next      = ptr;
    cnt_inc       = sat_inc(hold_cnt);
    err_set       = 1'b0;

    case (state)
      CPU_OWN: begin
        hold_cnt_next = '0;
        if ((bus.req_rx || bus.req_tx) && bus.cpu_bus_free) begin
          if (bus.req_rx && bus.req_tx) begin
            state_next = ptr ? GRANT_RX : GRANT_TX;
          end else if (bus.req_rx) begin
            state_next = GRANT_RX;
          end else begin
            state_next = GRANT_TX;
          end
        end
      end

      GRANT_RX: begin
        // The cycle that ends now is itself a grant cycle, so it counts
        // toward the watchdog even when the request is being dropped.
        err_set = (cnt_inc == HOLD_LIM);
        if (!bus.req_rx) begin
          state_next    = HANDOVER;
          hold_cnt_next = '0;
          ptr_next      = 1'b0;
        end else begin
          hold_cnt_next = cnt_inc;
        end
      end

      GRANT_TX: begin
        err_set = (cnt_inc == HOLD_LIM);
        if (!bus.req_tx) begin
          state_next    = HANDOVER;
          hold_cnt_next = '0;
          ptr_next      = 1'b1;
        end else begin
          hold_cnt_next = cnt_inc;
        end
      end

      HANDOVER: begin
        // Pending requests are arbitrated again only from CPU_OWN. This
        // gives the CPU at least one cycle between two DMA grants.
        state_next    = CPU_OWN;
        hold_cnt_next = '0;
      end

      default: begin
        state_next    = CPU_OWN;
        hold_cnt_next = '0;
      end
    endcase

    // When set and clear happen in the same cycle, the set wins.
    hold_err_next = err_set || (hold_err_q && !bus.err_clr);
  end

  // RAM port mux. It follows the registered state, so during reset it
  // passes the CPU inputs and during handover it drives all zeros.
  always_comb begin
    bus.ram_address = '0;
    bus.ram_cs      = 1'b0;
    bus.ram_oen     = 1'b0;
    bus.ram_wen     = 1'b0;
    case (state)
      CPU_OWN: begin
        bus.ram_address = bus.cpu_address;
        bus.ram_cs      = bus.cpu_cs;
        bus.ram_oen     = bus.cpu_oen;
        bus.ram_wen     = bus.cpu_wen;
      end
      GRANT_RX: begin
        bus.ram_address = bus.rx_address;
        bus.ram_cs      = bus.rx_cs;
        bus.ram_oen     = bus.rx_oen;
        bus.ram_wen     = bus.rx_wen;
      end
      GRANT_TX: begin
        bus.ram_address = bus.tx_address;
        bus.ram_cs      = bus.tx_cs;
        bus.ram_oen     = bus.tx_oen;
        bus.ram_wen     = bus.tx_wen;
      end
      default: begin
        bus.ram_address = '0;
        bus.ram_cs      = 1'b0;
        bus.ram_oen     = 1'b0;
        bus.ram_wen     = 1'b0;
      end
    endcase
  end

  assign bus.cpu_grant = cpu_grant_q;
  assign bus.gnt_rx    = gnt_rx_q;
  assign bus.gnt_tx    = gnt_tx_q;
  assign bus.owner     = state;
  assign bus.hold_err  = hold_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;

  localparam int ADDR_W   = 8;
  localparam int MAX_HOLD = 16;

  localparam logic [7:0] CPU_A = 8'h11;
  localparam logic [7:0] RX_A  = 8'h22;
  localparam logic [7:0] TX_A  = 8'h33;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dma_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dma_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .MAX_HOLD(MAX_HOLD),
    .RX_FIRST(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got=running exp=finished)");
    $fatal(1, "timeout");
  end

  // Move 1 time unit past the next rising edge. Outputs are sampled here and
  // new inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.cpu_bus_free = 1'b0;
    bus.cpu_address  = CPU_A;
    bus.cpu_cs       = 1'b1;
    bus.cpu_oen      = 1'b0;
    bus.cpu_wen      = 1'b1;
    bus.req_rx       = 1'b0;
    bus.rx_address   = RX_A;
    bus.rx_cs        = 1'b1;
    bus.rx_oen       = 1'b1;
    bus.rx_wen       = 1'b0;
    bus.req_tx       = 1'b0;
    bus.tx_address   = TX_A;
    bus.tx_cs        = 1'b1;
    bus.tx_oen       = 1'b0;
    bus.tx_wen       = 1'b0;
    bus.err_clr      = 1'b0;
    tick();
    tick();
    total++; if (bus.cpu_grant !== 1'b1) begin bad++; $display("FAIL reset_cpu_grant got=%b exp=1", bus.cpu_grant); end
    total++; if ({bus.gnt_rx, bus.gnt_tx} !== 2'b00) begin bad++; $display("FAIL reset_gnts got=%b exp=00", {bus.gnt_rx, bus.gnt_tx}); end
    total++; if (bus.owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
    total++; if (bus.hold_err !== 1'b0) begin bad++; $display("FAIL reset_hold_err got=%b exp=0", bus.hold_err); end
    total++; if ({bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen} !== {CPU_A, 3'b101}) begin
      bad++; $display("FAIL reset_ram_mux got=%h/%b%b%b exp=11/101", bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Both requests rise together: RX wins first (RX_FIRST=1). Then come one
  // handover cycle and one CPU cycle, and then TX is granted.
  task automatic test_tie_round_robin();
    bus.cpu_bus_free = 1'b1;
    bus.req_rx       = 1'b1;
    bus.req_tx       = 1'b1;
    tick();
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx} !== 3'b010) begin bad++; $display("FAIL tie_rx_first got=%b exp=010", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx}); end
    total++; if (bus.owner !== 2'd1) begin bad++; $display("FAIL tie_owner_rx got=%0d exp=1", bus.owner); end
    total++; if ({bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen} !== {RX_A, 3'b110}) begin
      bad++; $display("FAIL tie_ram_rx got=%h/%b%b%b exp=22/110", bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen);
    end
    // A TX request that toggles during the RX grant has no effect.
    bus.req_tx = 1'b0;
    tick();
    bus.req_tx = 1'b1;
    tick();
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx} !== 3'b010) begin bad++; $display("FAIL tie_other_toggle got=%b exp=010", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx}); end
    bus.req_rx = 1'b0;
    tick();
    total++; if (bus.owner !== 2'd3) begin bad++; $display("FAIL tie_handover_owner got=%0d exp=3", bus.owner); end
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx} !== 3'b000) begin bad++; $display("FAIL tie_handover_gnts got=%b exp=000", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx}); end
    total++; if ({bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen} !== 11'd0) begin
      bad++; $display("FAIL tie_handover_ram got=%h/%b%b%b exp=00/000", bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen);
    end
    tick();
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner} !== 5'b10000) begin bad++; $display("FAIL tie_cpu_gap got=%b exp=10000", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner}); end
    tick();
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner} !== 5'b00110) begin bad++; $display("FAIL tie_tx_second got=%b exp=00110", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner}); end
    total++; if ({bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen} !== {TX_A, 3'b100}) begin
      bad++; $display("FAIL tie_ram_tx got=%h/%b%b%b exp=33/100", bus.ram_address, bus.ram_cs, bus.ram_oen, bus.ram_wen);
    end
    bus.req_tx = 1'b0;
    tick();
    tick();
    total++; if ({bus.cpu_grant, bus.owner} !== 3'b100) begin bad++; $display("FAIL tie_back_to_cpu got=%b exp=100", {bus.cpu_grant, bus.owner}); end
  endtask

  // A TX request waits while the CPU is busy. Later, an async reset is
  // applied mid-grant.
  task automatic test_bus_busy_and_async_reset();
    bus.cpu_bus_free = 1'b0;
    bus.req_tx       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({bus.cpu_grant, bus.gnt_tx} !== 2'b10) begin bad++; $display("FAIL busy_wait_%0d got=%b exp=10", i, {bus.cpu_grant, bus.gnt_tx}); end
    end
    bus.cpu_bus_free = 1'b1;
    tick();
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner} !== 5'b00110) begin bad++; $display("FAIL busy_then_grant got=%b exp=00110", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner}); end
    bus.req_rx = 1'b1;
    tick();
    total++; if ({bus.gnt_rx, bus.gnt_tx} !== 2'b01) begin bad++; $display("FAIL tx_keeps_grant got=%b exp=01", {bus.gnt_rx, bus.gnt_tx}); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner} !== 5'b10000) begin bad++; $display("FAIL async_reset got=%b exp=10000", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx, bus.owner}); end
    total++; if (bus.ram_address !== CPU_A) begin bad++; $display("FAIL async_reset_ram got=%h exp=11", bus.ram_address); end
    bus.req_rx = 1'b0;
    bus.req_tx = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Watchdog: the flag sets after 16 grant cycles, the grant is kept, a set
  // in the same cycle beats a clear, and the counter restarts with each grant.
  task automatic test_hold_watchdog();
    bus.cpu_bus_free = 1'b1;
    bus.req_rx       = 1'b1;
    tick();
    total++; if (bus.gnt_rx !== 1'b1) begin bad++; $display("FAIL hold_granted got=%b exp=1", bus.gnt_rx); end
    for (int i = 1; i <= 20; i++) begin
      if (i == 18) bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      if (i == 15) begin
        total++; if (bus.hold_err !== 1'b0) begin bad++; $display("FAIL hold_early got=%b exp=0", bus.hold_err); end
      end
      if (i == 16) begin
        total++; if (bus.hold_err !== 1'b1) begin bad++; $display("FAIL hold_set got=%b exp=1", bus.hold_err); end
      end
      if (i == 18) begin
        total++; if (bus.hold_err !== 1'b1) begin bad++; $display("FAIL hold_set_wins got=%b exp=1", bus.hold_err); end
      end
    end
    total++; if ({bus.gnt_rx, bus.owner} !== 3'b101) begin bad++; $display("FAIL hold_grant_kept got=%b exp=101", {bus.gnt_rx, bus.owner}); end
    bus.req_rx = 1'b0;
    tick();
    tick();
    total++; if ({bus.cpu_grant, bus.hold_err} !== 2'b11) begin bad++; $display("FAIL hold_sticky got=%b exp=11", {bus.cpu_grant, bus.hold_err}); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    total++; if (bus.hold_err !== 1'b0) begin bad++; $display("FAIL hold_cleared got=%b exp=0", bus.hold_err); end
    // A short new grant must not set the flag again, because the counter
    // was cleared on release.
    bus.req_rx = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    total++; if ({bus.gnt_rx, bus.hold_err} !== 2'b10) begin bad++; $display("FAIL hold_restart got=%b exp=10", {bus.gnt_rx, bus.hold_err}); end
    bus.req_rx = 1'b0;
    tick();
    tick();
  endtask

  // A request dropped right after the grant gives a one-cycle grant.
  task automatic test_one_cycle_grant();
    bus.req_tx = 1'b1;
    tick();
    bus.req_tx = 1'b0;
    total++; if (bus.gnt_tx !== 1'b1) begin bad++; $display("FAIL short_grant got=%b exp=1", bus.gnt_tx); end
    tick();
    total++; if ({bus.gnt_tx, bus.owner} !== 3'b011) begin bad++; $display("FAIL short_handover got=%b exp=011", {bus.gnt_tx, bus.owner}); end
    tick();
    total++; if ({bus.cpu_grant, bus.owner} !== 3'b100) begin bad++; $display("FAIL short_cpu got=%b exp=100", {bus.cpu_grant, bus.owner}); end
  endtask

  // At most one grant may be high in any cycle.
  always @(negedge clk) begin
    if (rst_n && total > 0) begin
      total++;
      if ((32'(bus.cpu_grant) + 32'(bus.gnt_rx) + 32'(bus.gnt_tx)) > 1) begin
        bad++;
        $display("FAIL grant_exclusive got=%b exp=onehot_or_zero", {bus.cpu_grant, bus.gnt_rx, bus.gnt_tx});
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_tie_round_robin();
    test_bus_busy_and_async_reset();
    test_hold_watchdog();
    test_one_cycle_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
